seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider producing quotient and remainder for WIDTH-bit operands, one quotient bit per clock. Successor to the fixed 5-bit shift/subtract divider built from a separate controller, register and subtractor. Adds a START/BUSY/DONE handshake, a divide-by-zero flag and an optional signed mode. Sits as a shared arithmetic unit behind any block needing integer division.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed operation is enabled by defining DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_e;

    // Width of the iteration counter, which must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam logic [31:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then trial-subtract the divisor.
// Behaviour is the same whether or not DIV_SIGNED_EN is defined.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The top bit of rem_i is always zero here, so it serves as the sign guard of the subtraction.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        trial   = {rem_i[WIDTH], shifted} - {2'b00, div_i};
        if (!trial[WIDTH+1]) begin
            rem_o = trial[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with a START/BUSY/DONE handshake and a divide-by-zero flag.
// Defining DIV_SIGNED_EN enables two's-complement operands with truncating division.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_ZERO
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q;
    logic             dz_q;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
`ifdef DIV_SIGNED_EN
    logic             neg_q_q, neg_r_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_mag = DIVIDEND[WIDTH-1] ? -DIVIDEND : DIVIDEND;
        dvs_mag = DIVISOR[WIDTH-1]  ? -DIVISOR  : DIVISOR;
`else
        dvd_mag = DIVIDEND;
        dvs_mag = DIVISOR;
`endif
    end

    // On divide-by-zero quo_q holds the raw dividend, which becomes the remainder.
    always_comb begin
        quo_fix = quo_q;
        rem_fix = rem_q[WIDTH-1:0];
        if (dz_q) begin
            quo_fix = DIV_ZERO_QUO[WIDTH-1:0];
            rem_fix = quo_q;
        end
`ifdef DIV_SIGNED_EN
        else begin
            if (neg_q_q) quo_fix = -quo_q;
            if (neg_r_q) rem_fix = -rem_q[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            dz_q      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            DIV_ZERO  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        BUSY  <= 1'b1;
                        rem_q <= '0;
                        dz_q  <= (DIVISOR == '0);
`ifdef DIV_SIGNED_EN
                        neg_q_q <= DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1];
                        neg_r_q <= DIVIDEND[WIDTH-1];
`endif
                        if (DIVISOR == '0) begin
                            quo_q   <= DIVIDEND;
                            div_q   <= '0;
                            state_q <= FINISH;
                        end else begin
                            quo_q   <= dvd_mag;
                            div_q   <= dvs_mag;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FINISH;
                end
                FINISH: begin
                    QUOTIENT  <= quo_fix;
                    REMAINDER <= rem_fix;
                    DIV_ZERO  <= dz_q;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH 2, 8 and 32; follows DIV_SIGNED_EN if defined.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       s2, bz2, dn2, dz2;
    logic [1:0] a2, b2, q2, r2;
    logic       s8, bz8, dn8, dz8;
    logic [7:0] a8, b8, q8, r8;
    logic        s32, bz32, dn32, dz32;
    logic [31:0] a32, b32, q32, r32;

    seq_divider #(.WIDTH(2)) u2 (
        .CLK(clk), .RST_N(rst_n), .START(s2), .DIVIDEND(a2), .DIVISOR(b2),
        .BUSY(bz2), .DONE(dn2), .QUOTIENT(q2), .REMAINDER(r2), .DIV_ZERO(dz2));
    seq_divider #(.WIDTH(8)) u8 (
        .CLK(clk), .RST_N(rst_n), .START(s8), .DIVIDEND(a8), .DIVISOR(b8),
        .BUSY(bz8), .DONE(dn8), .QUOTIENT(q8), .REMAINDER(r8), .DIV_ZERO(dz8));
    seq_divider #(.WIDTH(32)) u32 (
        .CLK(clk), .RST_N(rst_n), .START(s32), .DIVIDEND(a32), .DIVISOR(b32),
        .BUSY(bz32), .DONE(dn32), .QUOTIENT(q32), .REMAINDER(r32), .DIV_ZERO(dz32));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wid(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 8 : 32;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 0) ? dn2 : (sel == 1) ? dn8 : dn32;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bz2 : (sel == 1) ? bz8 : bz32;
    endfunction
    function automatic logic get_dz(input int sel);
        return (sel == 0) ? dz2 : (sel == 1) ? dz8 : dz32;
    endfunction
    function automatic logic [31:0] get_q(input int sel);
        return (sel == 0) ? {30'b0, q2} : (sel == 1) ? {24'b0, q8} : q32;
    endfunction
    function automatic logic [31:0] get_r(input int sel);
        return (sel == 0) ? {30'b0, r2} : (sel == 1) ? {24'b0, r8} : r32;
    endfunction

    // Reference: plain integer division on W-bit operands (truncating when signed).
    function automatic void model(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint mask, a, b, sa, sb;
        mask = (longint'(1) << w) - 1;
        a = longint'(a_in) & mask;
        b = longint'(b_in) & mask;
        if (b == 0) begin
            q = 32'(mask); r = 32'(a); dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
            sb = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
`else
            sa = a;
            sb = b;
`endif
            q = 32'((sa / sb) & mask);
            r = 32'((sa % sb) & mask);
            dz = 1'b0;
        end
    endfunction

    // Issue one request; START is applied from #1 after an edge and accepted at the next edge.
    task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz, input string name);
        int lat, busy_n, exp_lat;
        case (sel)
            0: begin s2 = 1'b1; a2 = a[1:0]; b2 = b[1:0]; end
            1: begin s8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
            default: begin s32 = 1'b1; a32 = a; b32 = b; end
        endcase
        @(posedge clk); #1;
        s2 = 1'b0; s8 = 1'b0; s32 = 1'b0;
        lat = -1;
        busy_n = 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (get_busy(sel)) busy_n++;
            @(posedge clk); #1;
            if (get_done(sel)) lat = c;
        end
        exp_lat = edz ? 1 : wid(sel) + 1;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy_n, exp_lat);
        chk({name, "_busy_at_done"}, get_busy(sel), 1'b0);
        chk({name, "_quotient"}, get_q(sel), eq);
        chk({name, "_remainder"}, get_r(sel), er);
        chk({name, "_div_zero"}, get_dz(sel), edz);
    endtask

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dz;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        edz;
        logic [7:0]  q200, r200, qs, rs;
        int          ndone, dcyc;

        s2 = 0; s8 = 0; s32 = 0;
        a2 = 0; b2 = 0; a8 = 0; b8 = 0; a32 = 0; b32 = 0;
        rst_n = 1'b0;

`ifdef DIV_SIGNED_EN
        q200 = 8'hF8; r200 = 8'h00;
        tbl.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0});
        tbl.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0});
`else
        q200 = 8'd28; r200 = 8'd4;
        tbl.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
        tbl.push_back('{8'd1, 8'd255, 8'd0, 8'd1, 1'b0});
        tbl.push_back('{8'd128, 8'd2, 8'd64, 8'd0, 1'b0});
`endif
        tbl.push_back('{8'd200, 8'd7, q200, r200, 1'b0});
        tbl.push_back('{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1});
        tbl.push_back('{8'd3, 8'd10, 8'd0, 8'd3, 1'b0});
        tbl.push_back('{8'd0, 8'd1, 8'd0, 8'd0, 1'b0});
        tbl.push_back('{8'd42, 8'd42, 8'd1, 8'd0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bz8, 1'b0);
        chk("reset_done", dn8, 1'b0);
        chk("reset_quotient", q8, 8'd0);
        chk("reset_remainder", r8, 8'd0);
        chk("reset_div_zero", dz8, 1'b0);
        chk("reset_w32_quotient", q32, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            xfer(1, {24'b0, tbl[i].a}, {24'b0, tbl[i].b}, {24'b0, tbl[i].q}, {24'b0, tbl[i].r},
                 tbl[i].dz, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_single", i), dn8, 1'b0);
        end

        // Divide-by-zero, then a new request presented while DONE is still high.
        xfer(1, 32'd5, 32'd0, 32'hFF, 32'd5, 1'b1, "dz_first");
        chk("b2b_done_high", dn8, 1'b1);
        xfer(1, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, "b2b_second");

        // START pulsed mid-division with new operands must be ignored.
        s8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd3;
        @(posedge clk); #1;
        s8 = 1'b0;
        ndone = 0; dcyc = -1; qs = 0; rs = 0;
        for (int c = 5; c <= 30; c++) begin
            @(posedge clk); #1;
            if (dn8) begin
                ndone++;
                if (dcyc < 0) begin dcyc = c; qs = q8; rs = r8; end
            end
        end
        chk("mid_start_done_count", ndone, 1);
        chk("mid_start_latency", dcyc, 9);
        chk("mid_start_quotient", qs, q200);
        chk("mid_start_remainder", rs, r200);

        // Reset during a division aborts it.
        s8 = 1'b1; a8 = 8'd77; b8 = 8'd3;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bz8, 1'b0);
        chk("abort_done", dn8, 1'b0);
        chk("abort_quotient", q8, 8'd0);
        chk("abort_remainder", r8, 8'd0);
        chk("abort_div_zero", dz8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (dn8) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        xfer(1, 32'd255, 32'd255, 32'd1, 32'd0, 1'b0, "after_abort");

        // Random sweep over all three widths, plus the most-negative / all-ones corner.
        for (int sel = 0; sel < 3; sel++) begin
            for (int n = 0; n < 25; n++) begin
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = 32'd0;
                    1, 2: rb = rb & 32'h0000_000F;
                    default: ;
                endcase
                if (wid(sel) < 32) begin
                    ra = ra & ((32'd1 << wid(sel)) - 32'd1);
                    rb = rb & ((32'd1 << wid(sel)) - 32'd1);
                end
                model(wid(sel), ra, rb, eq, er, edz);
                xfer(sel, ra, rb, eq, er, edz, $sformatf("rand_w%0d_%0d", wid(sel), n));
            end
            ra = 32'd1 << (wid(sel) - 1);
            rb = (wid(sel) < 32) ? ((32'd1 << wid(sel)) - 32'd1) : 32'hFFFF_FFFF;
            model(wid(sel), ra, rb, eq, er, edz);
            xfer(sel, ra, rb, eq, er, edz, $sformatf("corner_w%0d", wid(sel)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
